// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared RX constants and the data-length type
package uart_rx_pkg;
  localparam int DATA_LEN_MIN = 5;
  typedef logic [3:0] len_t;
endpackage

// File: rtl/uart_rx_strobe_gen.sv
// uart_rx_strobe_gen: fires on the last oversampling edge of a bit period
module uart_rx_strobe_gen #(
  parameter int WIDTH = 6
) (
  input  logic             enable,
  input  logic [WIDTH-1:0] edge_count,
  input  logic [WIDTH-1:0] prescale,
  output logic             strobe
);
  assign strobe = enable && (edge_count == prescale - WIDTH'(1));
endmodule

// File: rtl/uart_rx_deser_multi.sv
// uart_rx_deser_multi: variable-length, bit-order-selectable UART data deserializer
module uart_rx_deser_multi
  import uart_rx_pkg::*;
#(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      sampled_bit,
  input  logic [PRESCALE_WIDTH-1:0] edge_count,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [3:0]                data_len,
  input  logic                      msb_first,
  output logic [MAX_DATA_WIDTH-1:0] p_data,
  output logic                      data_valid,
  output logic [3:0]                bit_count,
  output logic                      data_xor,
  output logic                      extra_bit
);
  localparam len_t LEN_MAX = len_t'(MAX_DATA_WIDTH);
  localparam logic [MAX_DATA_WIDTH-1:0] ONES = '1;
  logic strobe, cap;
  logic [MAX_DATA_WIDTH-1:0] shreg_q, shreg_d, shreg_nx, p_data_q, p_data_d;
  len_t bit_count_q, bit_count_d, len_q, len_d;
  logic data_xor_q, data_xor_d, extra_bit_q, extra_bit_d, order_q, order_d;
  logic data_valid_q, data_valid_d;

  uart_rx_strobe_gen #(.WIDTH(PRESCALE_WIDTH)) u_strobe (
    .enable     (enable),
    .edge_count (edge_count),
    .prescale   (prescale),
    .strobe     (strobe)
  );

  // clear restarts the frame; a strobe captures until full, then only flags overrun
  always_comb begin
    shreg_d      = shreg_q;
    p_data_d     = p_data_q;
    bit_count_d  = bit_count_q;
    len_d        = len_q;
    data_xor_d   = data_xor_q;
    extra_bit_d  = extra_bit_q;
    order_d      = order_q;
    data_valid_d = 1'b0;
    shreg_nx     = order_q ? {shreg_q[MAX_DATA_WIDTH-2:0], sampled_bit}
                           : {sampled_bit, shreg_q[MAX_DATA_WIDTH-1:1]};
    cap          = strobe && (bit_count_q < len_q);
    if (clear) begin
      shreg_d     = '0;
      bit_count_d = '0;
      data_xor_d  = 1'b0;
      extra_bit_d = 1'b0;
      len_d       = (data_len >= len_t'(DATA_LEN_MIN) && data_len <= LEN_MAX) ? data_len : LEN_MAX;
      order_d     = msb_first;
    end else if (cap) begin
      shreg_d     = shreg_nx;
      bit_count_d = bit_count_q + len_t'(1);
      data_xor_d  = data_xor_q ^ sampled_bit;
      if (bit_count_d == len_q) begin
        p_data_d     = order_q ? (shreg_nx & ~(ONES << len_q)) : (shreg_nx >> (LEN_MAX - len_q));
        data_valid_d = 1'b1;
      end
    end else if (strobe) begin
      extra_bit_d = 1'b1;
    end
  end

  // state register; reset restores the widest LSB-first configuration
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q      <= '0;
      p_data_q     <= '0;
      bit_count_q  <= '0;
      len_q        <= LEN_MAX;
      data_xor_q   <= 1'b0;
      extra_bit_q  <= 1'b0;
      order_q      <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      p_data_q     <= p_data_d;
      bit_count_q  <= bit_count_d;
      len_q        <= len_d;
      data_xor_q   <= data_xor_d;
      extra_bit_q  <= extra_bit_d;
      order_q      <= order_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = data_valid_q;
  assign bit_count  = bit_count_q;
  assign data_xor   = data_xor_q;
  assign extra_bit  = extra_bit_q;
endmodule

// File: tb/tb_uart_rx_deser_multi.sv
// tb_uart_rx_deser_multi: vector table, corner sequences and randomized model check
module tb_uart_rx_deser_multi;
  localparam int MAXW = 9;
  logic clk = 1'b0;
  logic rst_n, clear, enable, sampled_bit, msb_first;
  logic [5:0] edge_count, prescale;
  logic [3:0] data_len;
  logic [MAXW-1:0] p_data;
  logic data_valid, data_xor, extra_bit;
  logic [3:0] bit_count;
  int n_cmp = 0, n_bad = 0;

  bit mq[$];
  int m_len = MAXW, m_ord = 0;
  logic [MAXW-1:0] m_pd = '0;
  logic m_v = 1'b0, m_x = 1'b0;

  typedef struct {
    logic r, c, e, b;
    logic [5:0] ec, ps;
    logic [3:0] dl;
    logic mf;
    logic [MAXW-1:0] p;
    logic v;
    logic [3:0] bc;
    logic x, xe;
  } vec_t;
  vec_t tbl[$];

  uart_rx_deser_multi #(.MAX_DATA_WIDTH(MAXW), .PRESCALE_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .enable(enable), .sampled_bit(sampled_bit),
    .edge_count(edge_count), .prescale(prescale), .data_len(data_len), .msb_first(msb_first),
    .p_data(p_data), .data_valid(data_valid), .bit_count(bit_count), .data_xor(data_xor),
    .extra_bit(extra_bit)
  );

  always #5 clk = ~clk;

  function automatic logic m_parity();
    logic p = 1'b0;
    foreach (mq[i]) p ^= mq[i];
    return p;
  endfunction

  task automatic cyc(input logic r, c, e, b, input logic [5:0] ec, ps, input logic [3:0] dl, input logic mf);
    int v;
    rst_n = r; clear = c; enable = e; sampled_bit = b;
    edge_count = ec; prescale = ps; data_len = dl; msb_first = mf;
    @(posedge clk);
    #1;
    if (!r) begin
      mq.delete(); m_len = MAXW; m_ord = 0; m_pd = '0; m_v = 1'b0; m_x = 1'b0;
    end else begin
      m_v = 1'b0;
      if (c) begin
        mq.delete(); m_x = 1'b0; m_ord = int'(mf);
        m_len = (dl >= 5 && dl <= MAXW) ? int'(dl) : MAXW;
      end else if (e && int'(ec) == (int'(ps) + 63) % 64) begin
        if (mq.size() < m_len) begin
          mq.push_back(b);
          if (mq.size() == m_len) begin
            v = 0;
            for (int i = 0; i < m_len; i++)
              v += int'(mq[i]) * (1 << (m_ord != 0 ? m_len - 1 - i : i));
            m_pd = MAXW'(v);
            m_v = 1'b1;
          end
        end else m_x = 1'b1;
      end
    end
  endtask

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_exp(input string t, input int p, v, bc, x, xe);
    cmp({t, ".p_data"}, int'(p_data), p);
    cmp({t, ".data_valid"}, int'(data_valid), v);
    cmp({t, ".bit_count"}, int'(bit_count), bc);
    cmp({t, ".data_xor"}, int'(data_xor), x);
    cmp({t, ".extra_bit"}, int'(extra_bit), xe);
  endtask

  task automatic add(input logic r, c, e, b, input logic [5:0] ec, ps, input logic [3:0] dl,
                     input logic mf, input logic [MAXW-1:0] p, input logic v, input logic [3:0] bc,
                     input logic x, xe);
    vec_t w;
    w.r = r; w.c = c; w.e = e; w.b = b; w.ec = ec; w.ps = ps; w.dl = dl; w.mf = mf;
    w.p = p; w.v = v; w.bc = bc; w.x = x; w.xe = xe;
    tbl.push_back(w);
  endtask

  initial begin
    logic [5:0] ps, ec;
    // reset then LSB-first 8-bit frame 1,0,1,1,0,0,1,0
    add(0,0,0,0,0,8,8,0, 9'h000,0,0,0,0);
    add(1,1,0,0,0,8,8,0, 9'h000,0,0,0,0);
    add(1,0,1,1,7,8,8,0, 9'h000,0,1,1,0);
    add(1,0,1,0,7,8,8,0, 9'h000,0,2,1,0);
    add(1,0,1,1,7,8,8,0, 9'h000,0,3,0,0);
    add(1,0,1,1,7,8,8,0, 9'h000,0,4,1,0);
    add(1,0,1,0,7,8,8,0, 9'h000,0,5,1,0);
    add(1,0,1,0,7,8,8,0, 9'h000,0,6,1,0);
    add(1,0,1,1,7,8,8,0, 9'h000,0,7,0,0);
    add(1,0,1,0,7,8,8,0, 9'h04D,1,8,0,0);
    add(1,0,0,0,7,8,8,0, 9'h04D,0,8,0,0);
    add(1,0,1,1,3,8,8,0, 9'h04D,0,8,0,0);
    // same bits MSB-first
    add(1,1,0,0,0,8,8,1, 9'h04D,0,0,0,0);
    add(1,0,1,1,7,8,8,0, 9'h04D,0,1,1,0);
    add(1,0,1,0,7,8,8,0, 9'h04D,0,2,1,0);
    add(1,0,1,1,7,8,8,0, 9'h04D,0,3,0,0);
    add(1,0,1,1,7,8,8,0, 9'h04D,0,4,1,0);
    add(1,0,1,0,7,8,8,0, 9'h04D,0,5,1,0);
    add(1,0,1,0,7,8,8,0, 9'h04D,0,6,1,0);
    add(1,0,1,1,7,8,8,0, 9'h04D,0,7,0,0);
    add(1,0,1,0,7,8,8,0, 9'h0B2,1,8,0,0);
    // 5-bit frame then an overrun strobe
    add(1,1,0,0,0,8,5,0, 9'h0B2,0,0,0,0);
    add(1,0,1,1,7,8,5,0, 9'h0B2,0,1,1,0);
    add(1,0,1,1,7,8,5,0, 9'h0B2,0,2,0,0);
    add(1,0,1,0,7,8,5,0, 9'h0B2,0,3,0,0);
    add(1,0,1,0,7,8,5,0, 9'h0B2,0,4,0,0);
    add(1,0,1,1,7,8,5,0, 9'h013,1,5,1,0);
    add(1,0,1,1,7,8,5,0, 9'h013,0,5,1,1);
    add(1,0,0,0,7,8,5,0, 9'h013,0,5,1,1);
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].c, tbl[i].e, tbl[i].b, tbl[i].ec, tbl[i].ps, tbl[i].dl, tbl[i].mf);
      check_exp($sformatf("vec%0d", i), int'(tbl[i].p), int'(tbl[i].v), int'(tbl[i].bc),
                int'(tbl[i].x), int'(tbl[i].xe));
    end
    // illegal length falls back to 9; a mid-frame data_len change is ignored
    cyc(1,1,0,0,0,8,12,0);
    for (int i = 0; i < 5; i++) cyc(1,0,1,1,7,8, i < 3 ? 4'd12 : 4'd5, 0);
    check_exp("len12_mid", 'h013, 0, 5, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1,0,1,1,7,8,5,0);
    check_exp("len12_done", 'h1FF, 1, 9, 1, 0);
    cyc(1,0,0,0,0,8,5,0);
    check_exp("len12_after", 'h1FF, 0, 9, 1, 0);
    // clear wins over a coincident strobe; reset mid-frame drops the partial frame
    cyc(1,1,1,1,7,8,8,0);
    check_exp("clr_strobe", 'h1FF, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1,0,1,1,7,8,8,0);
    check_exp("pre_reset", 'h1FF, 0, 3, 1, 0);
    cyc(0,0,1,1,7,8,8,0);
    check_exp("mid_reset", 0, 0, 0, 0, 0);
    cyc(1,0,0,0,0,8,8,0);
    check_exp("post_reset", 0, 0, 0, 0, 0);
    // prescale 0 wraps: strobe only at edge_count all-ones
    cyc(1,1,0,0,0,0,5,0);
    cyc(1,0,1,1,6'h3F,0,5,0);
    check_exp("ps0_3f", 0, 0, 1, 1, 0);
    cyc(1,0,1,1,6'h00,0,5,0);
    check_exp("ps0_00", 0, 0, 1, 1, 0);
    // randomized traffic against the reference model
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 3))
        0: ps = 6'd0;
        1: ps = 6'd8;
        2: ps = 6'd16;
        default: ps = 6'($urandom);
      endcase
      ec = ($urandom_range(0, 1) != 0) ? ps - 6'd1 : 6'($urandom);
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 4) != 0,
          1'($urandom), ec, ps, 4'($urandom), 1'($urandom));
      check_exp("rand", int'(m_pd), int'(m_v), mq.size(), int'(m_parity()), int'(m_x));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
